proc_fetch: RTL and testbench

//  Instruction fetch sequencer. It reads the current PC from proc_pc, issues one

---
 rtl/proc_fetch.sv | 112 +++++++++++
 tb/tb_proc_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_fetch.sv
// Instruction fetch sequencer: PC -> imem request -> buffered word -> decode handshake.
// Optional misaligned-fetch fault guarded by PROC_FETCH_MISALIGN_CHK_EN.
module proc_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_INC     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output logic                  o_ld_pc,
  output logic [DATA_WIDTH-1:0] o_next_pc,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_gnt,
  input  logic                  i_imem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic                  o_instr_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0] o_instr_pc,
  input  logic                  i_instr_ready,
  input  logic                  i_redirect,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  output logic                  o_misalign
);

  localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(PC_INC);

`ifdef PROC_FETCH_MISALIGN_CHK_EN
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_FAULT} state_t;
`else
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;
`endif

  state_t                state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic                  pc_bad;
  logic                  grant;

`ifdef PROC_FETCH_MISALIGN_CHK_EN
  logic misalign_q;
  assign pc_bad     = (i_pc[1:0] != 2'b00);
  assign o_misalign = misalign_q;
`else
  assign pc_bad     = 1'b0;
  assign o_misalign = 1'b0;
`endif

  // A grant only counts while a request is actually being presented.
  assign grant       = (state == S_REQ) && !pc_bad && i_imem_gnt;
  assign o_imem_req  = rst_n && (state == S_REQ) && !pc_bad;
  assign o_imem_addr = i_pc;
  assign o_ld_pc     = rst_n && (i_redirect || grant);
  assign o_next_pc   = i_redirect ? i_redirect_pc : (i_pc + INC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_REQ;
      pc_q          <= '0;
      o_instr_valid <= 1'b0;
      o_instr       <= '0;
      o_instr_pc    <= '0;
`ifdef PROC_FETCH_MISALIGN_CHK_EN
      misalign_q    <= 1'b0;
`endif
    end else if (i_redirect) begin
      // Anything in flight or held belongs to the old path and is dropped.
      o_instr_valid <= 1'b0;
`ifdef PROC_FETCH_MISALIGN_CHK_EN
      misalign_q    <= 1'b0;
`endif
      case (state)
        S_REQ:   state <= grant ? S_DRAIN : S_REQ;
        S_WAIT:  state <= i_imem_rvalid ? S_REQ : S_DRAIN;
        S_DRAIN: state <= i_imem_rvalid ? S_REQ : S_DRAIN;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (pc_bad) begin
`ifdef PROC_FETCH_MISALIGN_CHK_EN
            state      <= S_FAULT;
            misalign_q <= 1'b1;
`endif
          end else if (grant) begin
            pc_q  <= i_pc;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            o_instr       <= i_imem_rdata;
            o_instr_pc    <= pc_q;
            o_instr_valid <= 1'b1;
            state         <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_instr_ready) begin
            o_instr_valid <= 1'b0;
            state         <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (i_imem_rvalid) state <= S_REQ;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_fetch.sv
// Self-checking bench for proc_fetch: a PC register model plus an instruction scoreboard.
module tb_proc_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        ld_pc;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  proc_fetch #(.DATA_WIDTH(32), .PC_INC(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_pc(pc), .o_ld_pc(ld_pc), .o_next_pc(next_pc),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(imem_gnt),
    .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .o_instr_valid(instr_valid), .o_instr(instr), .o_instr_pc(instr_pc),
    .i_instr_ready(instr_ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_misalign(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdy, input logic re, input logic [31:0] rpc);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    instr_ready = rdy;
    redirect    = re;
    redirect_pc = rpc;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Advance one clock; the PC register loads whatever was strobed this cycle.
  task automatic tick();
    logic        l;
    logic [31:0] n;
    l = ld_pc;
    n = next_pc;
    @(posedge clk);
    #1;
    if (l) pc = n;
  endtask

  // Scoreboard: every accepted instruction must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid && instr_ready && !redirect) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", instr, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_instr_pc", instr_pc, e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pc    = 32'h80;
    drv(0, 0, 0, 1, 1, 32'h1234);
    @(posedge clk); #1;
    settle();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_ld_pc", 32'(ld_pc), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_misalign", 32'(misalign), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drv(0, 0, 0, 1, 0, 0);

    // 1: basic fetch from 0x80
    settle();
    chk("t1_req0", 32'(imem_req), 1);
    chk("t1_addr0", imem_addr, 32'h80);
    chk("t1_ld0", 32'(ld_pc), 0);
    tick();
    drv(1, 0, 0, 1, 0, 0);
    settle();
    chk("t1_req", 32'(imem_req), 1);
    chk("t1_ld", 32'(ld_pc), 1);
    chk("t1_next", next_pc, 32'h84);
    tick();
    drv(0, 1, 32'h0050_0093, 1, 0, 0);
    sb.push_back('{32'h0050_0093, 32'h80});
    settle();
    chk("t1_wait_req", 32'(imem_req), 0);
    tick();
    drv(0, 0, 0, 1, 0, 0);
    settle();
    chk("t1_valid", 32'(instr_valid), 1);
    chk("t1_hold_req", 32'(imem_req), 0);
    tick();

    // 2: grant held off in REQ
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0);
      settle();
      chk("t2_req", 32'(imem_req), 1);
      chk("t2_addr", imem_addr, 32'h84);
      chk("t2_ld", 32'(ld_pc), 0);
      tick();
    end
    drv(1, 0, 0, 0, 0, 0);
    settle();
    chk("t2_addr_gnt", imem_addr, 32'h84);
    chk("t2_ld_gnt", 32'(ld_pc), 1);
    chk("t2_next", next_pc, 32'h88);
    tick();

    // 3: decode stalls for 5 cycles
    drv(0, 1, 32'h1111_1111, 0, 0, 0);
    sb.push_back('{32'h1111_1111, 32'h84});
    settle();
    tick();
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 32'hAAAA_AAAA, 0, 0, 0);
      settle();
      chk("t3_valid", 32'(instr_valid), 1);
      chk("t3_instr", instr, 32'h1111_1111);
      chk("t3_instr_pc", instr_pc, 32'h84);
      chk("t3_req", 32'(imem_req), 0);
      tick();
    end
    drv(0, 0, 0, 1, 0, 0);
    settle();
    chk("t3_req_at_rdy", 32'(imem_req), 0);
    tick();
    settle();
    chk("t3_req_after", 32'(imem_req), 1);
    chk("t3_valid_after", 32'(instr_valid), 0);

    // 4: redirect in WAIT, stale response drained
    drv(1, 0, 0, 1, 0, 0);
    settle();
    tick();
    drv(0, 0, 0, 1, 1, 32'h200);
    settle();
    chk("t4_ld", 32'(ld_pc), 1);
    chk("t4_next", next_pc, 32'h200);
    tick();
    drv(0, 0, 0, 1, 0, 0);
    settle();
    chk("t4_drain_req", 32'(imem_req), 0);
    tick();
    drv(0, 1, 32'hDEAD, 1, 0, 0);
    settle();
    chk("t4_drain_req2", 32'(imem_req), 0);
    tick();
    drv(0, 0, 0, 1, 0, 0);
    settle();
    chk("t4_valid", 32'(instr_valid), 0);
    chk("t4_req", 32'(imem_req), 1);
    chk("t4_addr", imem_addr, 32'h200);

    // 5: redirect coincident with grant
    drv(1, 0, 0, 1, 1, 32'h300);
    settle();
    chk("t5_ld", 32'(ld_pc), 1);
    chk("t5_next", next_pc, 32'h300);
    tick();
    drv(0, 1, 32'h0BAD, 1, 0, 0);
    settle();
    chk("t5_drain_req", 32'(imem_req), 0);
    tick();
    drv(0, 0, 0, 1, 0, 0);
    settle();
    chk("t5_valid", 32'(instr_valid), 0);
    chk("t5_addr", imem_addr, 32'h300);

    // redirect while holding with ready=1 drops the instruction
    drv(1, 0, 0, 1, 0, 0);
    settle();
    tick();
    drv(0, 1, 32'hCAFE_0001, 1, 0, 0);
    settle();
    tick();
    drv(0, 0, 0, 1, 1, 32'h400);
    settle();
    chk("hold_redir_next", next_pc, 32'h400);
    tick();
    drv(0, 0, 0, 1, 0, 0);
    settle();
    chk("hold_redir_valid", 32'(instr_valid), 0);
    chk("hold_redir_addr", imem_addr, 32'h400);

    // PC increment wraps at the top of the address space
    drv(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    settle();
    tick();
    drv(1, 0, 0, 1, 0, 0);
    settle();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_next", next_pc, 32'h0);
    tick();
    drv(0, 1, 32'h13, 1, 0, 0);
    sb.push_back('{32'h13, 32'hFFFF_FFFC});
    settle();
    tick();
    drv(0, 0, 0, 1, 0, 0);
    settle();
    tick();

    // 6: misaligned redirect target
    drv(0, 0, 0, 1, 1, 32'h202);
    settle();
    tick();
    drv(0, 0, 0, 1, 0, 0);
    settle();
`ifdef PROC_FETCH_MISALIGN_CHK_EN
    chk("t6_req", 32'(imem_req), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t6_misalign", 32'(misalign), 1);
      chk("t6_fault_req", 32'(imem_req), 0);
      chk("t6_fault_ld", 32'(ld_pc), 0);
      tick();
    end
    drv(0, 0, 0, 1, 1, 32'h300);
    settle();
    chk("t6_redir_ld", 32'(ld_pc), 1);
    tick();
    drv(0, 0, 0, 1, 0, 0);
    settle();
    chk("t6_misalign_clr", 32'(misalign), 0);
    chk("t6_req_after", 32'(imem_req), 1);
    chk("t6_addr_after", imem_addr, 32'h300);
`else
    chk("t6_req", 32'(imem_req), 1);
    chk("t6_addr", imem_addr, 32'h202);
    chk("t6_misalign", 32'(misalign), 0);
`endif
    tick();

    chk("sb_leftover", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
